// File: rtl/upuart_pkg.sv
// upuart_pkg: shared OCP encodings, arbiter FSM state codes and UART
// register offsets used by the UART slave-side arbiter.
package upuart_pkg;

    typedef logic [2:0] ocp_cmd_t;
    typedef logic [1:0] ocp_resp_t;
    typedef logic [1:0] arb_state_t;

    // OCP command encodings
    localparam ocp_cmd_t OCP_CMD_IDLE  = 3'd0;
    localparam ocp_cmd_t OCP_CMD_WRITE = 3'd1;
    localparam ocp_cmd_t OCP_CMD_READ  = 3'd2;

    // OCP response encodings
    localparam ocp_resp_t OCP_RESP_NULL = 2'd0;
    localparam ocp_resp_t OCP_RESP_DVA  = 2'd1;

    // Arbiter FSM states
    localparam arb_state_t ARB_ST_IDLE = 2'd0;
    localparam arb_state_t ARB_ST_CMD  = 2'd1;
    localparam arb_state_t ARB_ST_RESP = 2'd2;

    // UART register offsets
    localparam logic [11:0] UART_REG_IMASK = 12'h000;
    localparam logic [11:0] UART_REG_BAUD  = 12'h004;
    localparam logic [11:0] UART_REG_DATA  = 12'h008;

    // Any command other than IDLE counts as a pending request.
    function automatic logic ocp_is_req(input ocp_cmd_t cmd);
        return cmd != OCP_CMD_IDLE;
    endfunction

endpackage

// File: rtl/upuart_rr_arb2.sv
// upuart_rr_arb2: combinational two-requester round-robin picker.
// On a tie the requester that was not granted last time wins.
module upuart_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    // Pick the single requester, or alternate on a tie.
    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/upuart_ocp_arb.sv
// upuart_ocp_arb: shares one upuart_top OCP slave port between two masters.
// Round-robin grant, one outstanding transaction, responses routed to the
// issuing master, interrupt fanned out to both masters.
// Build option: define UPUART_ARB_WRRESP_EN to make writes non-posted
// (the FSM waits in RESP for the slave's DVA and forwards it).
module upuart_ocp_arb
    import upuart_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [AW-1:0]     i_m0_MAddr,
    input  logic [2:0]        i_m0_MCmd,
    input  logic [DW-1:0]     i_m0_MData,
    input  logic [DW/8-1:0]   i_m0_MByteEn,
    output logic              o_m0_SCmdAccept,
    output logic [DW-1:0]     o_m0_SData,
    output logic [1:0]        o_m0_SResp,
    output logic              o_m0_intr,

    input  logic [AW-1:0]     i_m1_MAddr,
    input  logic [2:0]        i_m1_MCmd,
    input  logic [DW-1:0]     i_m1_MData,
    input  logic [DW/8-1:0]   i_m1_MByteEn,
    output logic              o_m1_SCmdAccept,
    output logic [DW-1:0]     o_m1_SData,
    output logic [1:0]        o_m1_SResp,
    output logic              o_m1_intr,

    output logic [AW-1:0]     o_MAddr,
    output logic [2:0]        o_MCmd,
    output logic [DW-1:0]     o_MData,
    output logic [DW/8-1:0]   o_MByteEn,
    input  logic              i_SCmdAccept,
    input  logic [DW-1:0]     i_SData,
    input  logic [1:0]        i_SResp,
    input  logic              i_intr
);

    arb_state_t          state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [AW-1:0]       maddr_q, maddr_d;
    ocp_cmd_t            mcmd_q, mcmd_d;
    logic [DW-1:0]       mdata_q, mdata_d;
    logic [DW/8-1:0]     mbyteen_q, mbyteen_d;

    logic [1:0]          req;
    logic                arb_grant;
    logic                arb_valid;
    logic                in_cmd;
    logic                in_resp;

    assign req = {ocp_is_req(i_m1_MCmd), ocp_is_req(i_m0_MCmd)};

    upuart_rr_arb2 u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    // FSM next state and registered slave-side command.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        maddr_d      = maddr_q;
        mcmd_d       = mcmd_q;
        mdata_d      = mdata_q;
        mbyteen_d    = mbyteen_q;
        case (state_q)
            ARB_ST_IDLE: begin
                if (arb_valid) begin
                    state_d      = ARB_ST_CMD;
                    owner_d      = arb_grant;
                    last_grant_d = arb_grant;
                    if (arb_grant) begin
                        maddr_d   = i_m1_MAddr;
                        mcmd_d    = i_m1_MCmd;
                        mdata_d   = i_m1_MData;
                        mbyteen_d = i_m1_MByteEn;
                    end else begin
                        maddr_d   = i_m0_MAddr;
                        mcmd_d    = i_m0_MCmd;
                        mdata_d   = i_m0_MData;
                        mbyteen_d = i_m0_MByteEn;
                    end
                end
            end
            ARB_ST_CMD: begin
                if (i_SCmdAccept) begin
                    mcmd_d = OCP_CMD_IDLE;
                    if (mcmd_q == OCP_CMD_READ) begin
                        state_d = ARB_ST_RESP;
                    end else begin
`ifdef UPUART_ARB_WRRESP_EN
                        state_d = ARB_ST_RESP;
`else
                        state_d = ARB_ST_IDLE;
`endif
                    end
                end
            end
            ARB_ST_RESP: begin
                if (i_SResp == OCP_RESP_DVA) begin
                    state_d = ARB_ST_IDLE;
                end
            end
            default: begin
                state_d = ARB_ST_IDLE;
                mcmd_d  = OCP_CMD_IDLE;
            end
        endcase
    end

    // State and command registers; last_grant resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            maddr_q      <= '0;
            mcmd_q       <= OCP_CMD_IDLE;
            mdata_q      <= '0;
            mbyteen_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            maddr_q      <= maddr_d;
            mcmd_q       <= mcmd_d;
            mdata_q      <= mdata_d;
            mbyteen_q    <= mbyteen_d;
        end
    end

    assign in_cmd  = (state_q == ARB_ST_CMD);
    assign in_resp = (state_q == ARB_ST_RESP);

    assign o_MAddr   = maddr_q;
    assign o_MCmd    = mcmd_q;
    assign o_MData   = mdata_q;
    assign o_MByteEn = mbyteen_q;

    // Route accept and response to the owner only; the other master sees idle values.
    always_comb begin
        o_m0_SCmdAccept = in_cmd & ~owner_q & i_SCmdAccept;
        o_m1_SCmdAccept = in_cmd &  owner_q & i_SCmdAccept;
        o_m0_SResp      = OCP_RESP_NULL;
        o_m0_SData      = '0;
        o_m1_SResp      = OCP_RESP_NULL;
        o_m1_SData      = '0;
        if (in_resp) begin
            if (owner_q) begin
                o_m1_SResp = i_SResp;
                o_m1_SData = i_SData;
            end else begin
                o_m0_SResp = i_SResp;
                o_m0_SData = i_SData;
            end
        end
    end

    assign o_m0_intr = i_intr;
    assign o_m1_intr = i_intr;

endmodule

// File: doc/upuart_ocp_arb.md
# upuart_ocp_arb

Two-master OCP arbiter that shares one `upuart_top` OCP slave port between two requesters, for example a CPU data port and a DMA or debug master. It sits between the bus masters and the UART. It serialises commands with round-robin grant, routes each response back to the master that issued the command, and fans the UART interrupt out to both masters.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `i_mN_MAddr`  in  AW  master N address (N = 0, 1).
- `i_mN_MCmd`  in  3  master N command: IDLE=0, WRITE=1, READ=2.
- `i_mN_MData`  in  DW  master N write data.
- `i_mN_MByteEn`  in  DW/8  master N byte enables.
- `o_mN_SCmdAccept`  out  1  command accept to master N.
- `o_mN_SData`  out  DW  read data to master N.
- `o_mN_SResp`  out  2  response to master N: NULL=0, DVA=1.
- `o_mN_intr`  out  1  copy of `i_intr` for master N.
- `o_MAddr`, `o_MCmd`, `o_MData`, `o_MByteEn`  out  AW/3/DW/DW/8  command to the UART slave.
- `i_SCmdAccept`  in  1  command accept from the UART slave.
- `i_SData`  in  DW  read data from the UART slave.
- `i_SResp`  in  2  response from the UART slave.
- `i_intr`  in  1  UART interrupt.

## Operation
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - A request is any `MCmd != IDLE`.
  - If exactly one master requests, that master is granted.
  - If both request, the master other than `last_grant` is granted.
  - On grant, the arbiter registers the master's MAddr/MCmd/MData/MByteEn onto the slave outputs, sets `owner`, updates `last_grant`, and moves to CMD.
- CMD:
  - Slave outputs hold stable.
  - `o_m<owner>_SCmdAccept = i_SCmdAccept` (combinational). The requester holds its command until it sees accept.
  - When `i_SCmdAccept` is high:
    - A READ moves to RESP and drives `o_MCmd` to IDLE from the next cycle.
    - A WRITE moves to IDLE, or to RESP when `UPUART_ARB_WRRESP_EN` is defined.
- RESP:
  - `o_m<owner>_SResp/SData` follow `i_SResp/i_SData` combinationally.
  - The non-owner always sees SResp=NULL and SData=0.
  - On `i_SResp == DVA`, the arbiter returns to IDLE.
- One outstanding transaction at a time; no pipelining.
- The non-granted master's SCmdAccept stays 0. Its command must remain pending; it is not dropped.
- A master that withdraws its command in IDLE before grant is simply not granted.
- Interrupt: `o_m0_intr = o_m1_intr = i_intr`, unregistered.

## Timing
- Reset values:
  - FSM = IDLE, `owner` = 0, `last_grant` = 1, so m0 wins the first tie.
  - `o_MCmd` = IDLE; `o_MAddr`, `o_MData`, `o_MByteEn` = 0.
  - All SCmdAccept = 0, all SResp = NULL, all SData = 0.
- Latency: a request sampled in IDLE at edge N appears on `o_MCmd` after edge N. If the slave accepts in the same cycle, the master sees SCmdAccept in cycle N+1.
- Read: the response reaches the master in the cycle the slave drives DVA. The next grant is evaluated in IDLE one cycle after DVA.
- Back-to-back from one master: at least one IDLE cycle between transactions.
- Fairness: with both masters continuously requesting, grants alternate m0, m1, m0, …
- A DVA arriving while in CMD or IDLE is ignored and not forwarded.
- Reset asserted mid-transaction returns to reset values immediately. Any in-flight slave response after reset is discarded.

## Configuration
- `UPUART_ARB_WRRESP_EN`:
  - Defined: writes are non-posted; the FSM waits in RESP for DVA, which is forwarded to the owner.
  - Undefined: writes complete on accept, and any write response from the slave is ignored.

## Structure
- Shared package `upuart_pkg` holds:
  - OCP command encodings (IDLE/WRITE/READ).
  - Response encodings (NULL/DVA).
  - Arbiter FSM state encodings.
  - UART register offsets: 0x000 interrupt mask, 0x004 baud divisor, 0x008 data.
- One sub-module, `upuart_rr_arb2`: combinational two-requester round-robin picker (req[1:0], last_grant → grant, valid).
- The FSM and datapath stay in the top module.

## Test plan
- **Single master write:** m0 writes 0x004 = 27 to the baud register → slave sees WRITE/0x004/27 one cycle later; m0 gets SCmdAccept; m1 sees nothing.
- **Tie:** m0 and m1 both write in the same cycle, to 0x000 (data 1) and 0x008 (data 0x2A) → m0 is served first, then m1; the slave sees exactly two commands in that order.
- **Read routing:** m1 reads 0x008 while the UART has received 0x2B → `o_m1_SResp` = DVA and `o_m1_SData` = 0x2B; `o_m0_SResp` stays NULL.
- **Fairness:** both masters request continuously for 8 transactions → grants alternate, 4 each, starting with m0 after reset.
- **Write response:** build with and without `UPUART_ARB_WRRESP_EN`; the slave returns DVA on a write → with the macro, DVA is forwarded and the FSM waits for it; without, the FSM is back in IDLE the cycle after accept.
- **Reset mid-read:** assert `rst` in RESP → all outputs return to reset values immediately; a late DVA is not forwarded; the next tie grants m0.
